// File: rtl/dram_write_burst.sv
// Command/data FIFOs feeding a single-outstanding AXI4 INCR write master; DRAM_WRITE_BURST_PERF_EN adds perf counters.
// Latency: awvalid rises on the 2nd cycle after ctrl_we when the burst's data is already buffered.
// Backpressure: ctrl_full/data_full while FIFOs are full; pushes into a full FIFO are dropped and set err_ovf.

module dram_write_burst_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    // A simultaneous pop frees the slot, so a push while full still lands.
    assign wr_en = push && (!full || rd_en);
    assign drop  = push && !wr_en;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module dram_write_burst #(
    parameter int CMD_DEPTH  = 16,
    parameter int DATA_DEPTH = 512,
    parameter int ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [39:0]       ctrl_in,
    input  logic              ctrl_we,
    input  logic [35:0]       data_in,
    input  logic              data_we,
    output logic              ctrl_full,
    output logic              data_full,
    output logic              idle,
    output logic              err_resp,
    output logic              err_ovf,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready
`ifdef DRAM_WRITE_BURST_PERF_EN
    ,
    output logic [31:0]       perf_bursts,
    output logic [31:0]       perf_beats,
    output logic [31:0]       perf_stall
`endif
);
    localparam int CW = $clog2(CMD_DEPTH) + 1;
    localparam int DW = $clog2(DATA_DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cmd_cnt;
    logic [DW-1:0] data_cnt;
    logic [39:0]   cmd_dat;
    logic [35:0]   data_dat;
    logic          cmd_vld;
    logic          cmd_drop;
    logic          data_drop;
    logic          data_pop;
    logic          start;
    logic [7:0]    cmd_len;
    logic [8:0]    need;
    logic [8:0]    beat_cnt;

    dram_write_burst_fifo #(.W(40), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (ctrl_we),
        .pop   (start),
        .din   (ctrl_in),
        .dout  (cmd_dat),
        .count (cmd_cnt),
        .drop  (cmd_drop)
    );

    dram_write_burst_fifo #(.W(36), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (data_we),
        .pop   (data_pop),
        .din   (data_in),
        .dout  (data_dat),
        .count (data_cnt),
        .drop  (data_drop)
    );

    assign cmd_vld   = (cmd_cnt != '0);
    assign cmd_len   = cmd_dat[39:32];
    assign need      = (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
    assign ctrl_full = (cmd_cnt == CW'(CMD_DEPTH));
    assign data_full = (data_cnt == DW'(DATA_DEPTH));
    assign idle      = !cmd_vld && (data_cnt == '0) && (state_q == S_IDLE);

    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        start         = 1'b0;
        data_pop      = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_bready  = 1'b0;
        case (state_q)
            // Waiting for the whole burst to be buffered keeps wvalid solid once W starts.
            S_IDLE: begin
                if (cmd_vld && (data_cnt >= DW'(need))) begin
                    start   = 1'b1;
                    state_d = S_AW;
                end
            end
            S_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                m_axi_wvalid = 1'b1;
                m_axi_wdata  = data_dat[31:0];
                m_axi_wstrb  = data_dat[35:32];
                m_axi_wlast  = (beat_cnt == 9'd1);
                if (m_axi_wready) begin
                    data_pop = 1'b1;
                    if (beat_cnt == 9'd1) begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_axi_awaddr <= '0;
            m_axi_awlen  <= '0;
            beat_cnt     <= '0;
            err_resp     <= 1'b0;
            err_ovf      <= 1'b0;
        end else begin
            if (start) begin
                m_axi_awaddr <= ADDR_W'(cmd_dat[31:0]);
                m_axi_awlen  <= cmd_len - 8'd1;
                beat_cnt     <= need;
            end else if (data_pop) begin
                beat_cnt <= beat_cnt - 9'd1;
            end
            if ((state_q == S_B) && m_axi_bvalid && (m_axi_bresp != 2'b00)) begin
                err_resp <= 1'b1;
            end
            if (cmd_drop || data_drop) begin
                err_ovf <= 1'b1;
            end
        end
    end

`ifdef DRAM_WRITE_BURST_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_bursts <= '0;
            perf_beats  <= '0;
            perf_stall  <= '0;
        end else begin
            if ((state_q == S_B) && m_axi_bvalid) begin
                perf_bursts <= perf_bursts + 32'd1;
            end
            if (data_pop) begin
                perf_beats <= perf_beats + 32'd1;
            end
            if (m_axi_wvalid && !m_axi_wready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dram_write_burst.sv
// Scoreboard bench for dram_write_burst: stimulus queues expected AW/W traffic, a monitor checks DUT handshakes.
`timescale 1ns/1ps

module tb_dram_write_burst;
    localparam int CMD_DEPTH  = 16;
    localparam int DATA_DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] ctrl_in;
    logic        ctrl_we;
    logic [35:0] data_in;
    logic        data_we;
    logic        ctrl_full, data_full, idle, err_resp, err_ovf;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    always #5 clk = ~clk;

    dram_write_burst #(.CMD_DEPTH(CMD_DEPTH), .DATA_DEPTH(DATA_DEPTH), .ADDR_W(32)) dut (
        .CLK           (clk),
        .RST           (rst),
        .ctrl_in       (ctrl_in),
        .ctrl_we       (ctrl_we),
        .data_in       (data_in),
        .data_we       (data_we),
        .ctrl_full     (ctrl_full),
        .data_full     (data_full),
        .idle          (idle),
        .err_resp      (err_resp),
        .err_ovf       (err_ovf),
        .m_axi_awaddr  (awaddr),
        .m_axi_awlen   (awlen),
        .m_axi_awsize  (awsize),
        .m_axi_awburst (awburst),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wlast   (wlast),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [35:0] exp_w[$];
    logic [39:0] exp_aw[$];
    int          cur_beats = 0;
    int          beat_idx = 0;
    int          n_b_hs = 0;
    int          n_b_exp = 0;
    int          n_w_hs = 0;
    int          aw_stall_left = 0;
    bit          aw_en = 1'b1;
    int          w_mode = 0;
    logic [1:0]  bresp_next = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // AXI slave: readiness patterns and a single-beat B response after each WLAST.
    initial begin
        logic aw_seen, wl, bh;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        forever begin
            @(negedge clk);
            aw_seen = awvalid;
            wl      = wvalid && wready && wlast;
            bh      = bvalid && bready;
            @(posedge clk);
            #1;
            if (rst) begin
                bvalid = 1'b0;
            end else begin
                if (bh) bvalid = 1'b0;
                if (wl) begin
                    bvalid = 1'b1;
                    bresp  = bresp_next;
                end
            end
            if (aw_seen && aw_stall_left > 0) aw_stall_left--;
            awready = aw_en && (aw_stall_left == 0);
            case (w_mode)
                0:       wready = 1'b1;
                1:       wready = ~wready;
                default: wready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops expectations on handshakes and checks stability while stalled.
    initial begin
        logic        prev_aw_wait, prev_w_wait;
        logic [39:0] prev_aw, e_aw;
        logic [36:0] prev_w;
        logic [35:0] e_w;
        logic [7:0]  e_awlen;
        prev_aw_wait = 1'b0;
        prev_w_wait  = 1'b0;
        prev_aw      = '0;
        prev_w       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_aw_wait = 1'b0;
                prev_w_wait  = 1'b0;
            end else begin
                if (awvalid || wvalid) chk("aw_w_overlap", awvalid && wvalid, 0);
                if (prev_aw_wait) chk("aw_stable", {awvalid, awlen, awaddr}, {1'b1, prev_aw});
                if (prev_w_wait) chk("w_stable", {wvalid, wlast, wstrb, wdata}, {1'b1, prev_w});
                if (awvalid && awready) begin
                    if (exp_aw.size() == 0) begin
                        chk("aw_unexpected", awvalid, 0);
                    end else begin
                        e_aw    = exp_aw.pop_front();
                        e_awlen = e_aw[39:32] - 8'd1;
                        chk("awaddr", awaddr, e_aw[31:0]);
                        chk("awlen", awlen, e_awlen);
                        chk("awsize_burst", {awsize, awburst}, {3'b010, 2'b01});
                        cur_beats = (e_aw[39:32] == 8'd0) ? 256 : int'(e_aw[39:32]);
                        beat_idx  = 0;
                    end
                end
                if (wvalid && wready) begin
                    n_w_hs++;
                    beat_idx++;
                    if (exp_w.size() == 0) begin
                        chk("w_unexpected", wvalid, 0);
                    end else begin
                        e_w = exp_w.pop_front();
                        chk("wstrb_wdata", {wstrb, wdata}, e_w);
                    end
                    chk("wlast", wlast, beat_idx == cur_beats);
                end
                if (bvalid && bready) n_b_hs++;
                prev_aw_wait = awvalid && !awready;
                prev_aw      = {awlen, awaddr};
                prev_w_wait  = wvalid && !wready;
                prev_w       = {wlast, wstrb, wdata};
            end
        end
    end

    task automatic push_data(input logic [35:0] d);
        data_in = d;
        data_we = 1'b1;
        @(posedge clk);
        #1;
        data_we = 1'b0;
        exp_w.push_back(d);
    endtask

    task automatic push_rand_data(input int n);
        for (int i = 0; i < n; i++) push_data({4'($urandom), 32'($urandom)});
    endtask

    task automatic push_ctrl(input logic [7:0] len, input logic [31:0] addr, input bit track);
        ctrl_in = {len, addr};
        ctrl_we = 1'b1;
        @(posedge clk);
        #1;
        ctrl_we = 1'b0;
        if (track) begin
            exp_aw.push_back({len, addr});
            n_b_exp++;
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (idle && !bvalid) break;
        end
        chk({name, "_idle"}, idle, 1);
        chk({name, "_bursts"}, n_b_hs, n_b_exp);
        chk({name, "_queues"}, exp_w.size() + exp_aw.size(), 0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_valids"}, {awvalid, wvalid, wlast, bready}, 0);
        chk({name, "_aw"}, {awlen, awaddr}, 0);
        chk({name, "_errs"}, {err_resp, err_ovf}, 0);
        chk({name, "_fulls"}, {ctrl_full, data_full}, 0);
        chk({name, "_idle"}, idle, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        ctrl_in = '0;
        ctrl_we = 1'b0;
        data_in = '0;
        data_we = 1'b0;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // Data first, then command, all ready.
        w_mode = 0;
        for (int i = 0; i < 64; i++) push_data({4'hf, 32'(i)});
        push_ctrl(8'd64, 32'h0100_0000, 1'b1);
        chk("latency_c1", awvalid, 0);
        @(posedge clk);
        #1;
        chk("latency_c2", awvalid, 1);
        wait_idle("t1");

        // Command first, data 40 cycles later.
        push_ctrl(8'd64, 32'h0100_0100, 1'b1);
        repeat (40) begin
            @(negedge clk);
            chk("t2_aw_wait", awvalid, 0);
        end
        for (int i = 0; i < 64; i++) begin
            push_data({4'($urandom), 32'($urandom)});
            chk("t2_aw_early", awvalid, 0);
        end
        wait_idle("t2");

        // AW stall and toggling wready.
        w_mode        = 1;
        aw_stall_left = 5;
        w0            = n_w_hs;
        push_rand_data(64);
        push_ctrl(8'd64, 32'h0100_0200, 1'b1);
        wait_idle("t3");
        chk("t3_aw_stalls", aw_stall_left, 0);
        chk("t3_beats", n_w_hs - w0, 64);

        // len 0 means 256 beats.
        w_mode = 2;
        w0     = n_w_hs;
        push_rand_data(256);
        push_ctrl(8'd0, 32'h0200_0000, 1'b1);
        wait_idle("t4");
        chk("t4_beats", n_w_hs - w0, 256);

        // SLVERR response, then OKAY bursts keep the sticky flag.
        chk("t5_err_pre", err_resp, 0);
        bresp_next = 2'b10;
        push_rand_data(4);
        push_ctrl(8'd4, 32'h0300_0000, 1'b1);
        wait_idle("t5a");
        chk("t5_err_set", err_resp, 1);
        bresp_next = 2'b00;
        for (int b = 0; b < 2; b++) begin
            push_rand_data(8);
            push_ctrl(8'd8, 32'h0300_0100 + 32'(b * 64), 1'b1);
            wait_idle("t5b");
            chk("t5_err_sticky", err_resp, 1);
        end

        // Random mix of command-first and data-first bursts, issued back to back.
        for (int b = 0; b < 6; b++) begin
            int n;
            logic [31:0] addr;
            n             = $urandom_range(1, 32);
            addr          = 32'($urandom) & 32'hFFFF_FF00;
            aw_stall_left = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                push_ctrl(8'(n), addr, 1'b1);
                repeat ($urandom_range(0, 10)) @(posedge clk);
                #1;
                push_rand_data(n);
            end else begin
                push_rand_data(n);
                push_ctrl(8'(n), addr, 1'b1);
            end
        end
        wait_idle("t6");
        chk("t6_no_ovf", err_ovf, 0);

        // Command FIFO overflow with no data available.
        aw_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push_ctrl(8'd8, 32'h0400_0000 + 32'(i * 32), 1'b0);
            if (i == 14) chk("t7_not_full_15", ctrl_full, 0);
            if (i == 15) chk("t7_full_16", {ctrl_full, err_ovf}, 2'b10);
            if (i == 16) chk("t7_ovf_17", {ctrl_full, err_ovf}, 2'b11);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("t7_rst");
        @(negedge clk);
        rst   = 1'b0;
        aw_en = 1'b1;

        // Asynchronous reset mid-burst.
        w_mode = 0;
        w0     = n_w_hs;
        push_rand_data(64);
        push_ctrl(8'd64, 32'h0500_0000, 1'b1);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (n_w_hs - w0 >= 20) break;
        end
        chk("t8_mid_burst", wvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("t8_rst");
        exp_w.delete();
        exp_aw.delete();
        n_b_exp   = n_b_hs;
        cur_beats = 0;
        beat_idx  = 0;
        #20;
        @(negedge clk);
        rst = 1'b0;
        push_rand_data(8);
        push_ctrl(8'd8, 32'h0500_1000, 1'b1);
        wait_idle("t8_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
